ram_dp_clr: RTL and testbench
=============================

RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words; DEPTH <= 2**ADDRESS_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from rEn sample to rData/rValid; legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0: 0 = read-old (old data on read-during-write), 1 = write-first (new data).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port wEn, input, 1, write request.
REQ-009 SHALL have port wAddr, input, ADDRESS_WIDTH, write address.
REQ-010 SHALL have port wData, input, DATA_WIDTH, write data.
REQ-011 SHALL have port wByteEn, input, DATA_WIDTH/8, per-byte write enable; bit i covers wData[8i+7:8i].
REQ-012 SHALL have port rEn, input, 1, read request.
REQ-013 SHALL have port rAddr, input, ADDRESS_WIDTH, read address.
REQ-014 SHALL have port clr, input, 1, request to zero the whole array.
REQ-015 SHALL have port rData, output, DATA_WIDTH, read data.
REQ-016 SHALL have port rValid, output, 1, one-cycle pulse marking rData updated by a read.
REQ-017 SHALL have port ready, output, 1, high when array is usable (not clearing).

Function
REQ-018 SHALL implement two states: CLEAR, READY.
REQ-019 CLEAR: SHALL write 0 to one address per cycle via an internal counter, 0 through DEPTH-1 ascending; after the cycle writing DEPTH-1, SHALL enter READY with counter reset to 0.
REQ-020 Full clear SHALL take exactly DEPTH cycles; ready SHALL rise on the DEPTH-th posedge after entering CLEAR.
REQ-021 READY: clr=1 at a posedge SHALL enter CLEAR; ready low from that edge.
REQ-022 clr during CLEAR SHALL be ignored; clear is not restarted.
REQ-023 During CLEAR, wEn and rEn SHALL be ignored; no user write lands, rValid stays 0, rData holds.
REQ-024 Write (READY, wEn=1, wAddr < DEPTH): SHALL update only bytes with wByteEn bit set, at that posedge; other bytes unchanged.
REQ-025 wAddr >= DEPTH or wByteEn all-zero SHALL leave the array unchanged; no error flagged.
REQ-026 Read (READY, rEn=1) sampled at edge N: rData and rValid=1 SHALL appear after edge N+READ_LATENCY-1 (latency 1: visible in the cycle after edge N).
REQ-027 rAddr >= DEPTH SHALL return 0 with rValid=1.
REQ-028 rValid SHALL be 0 in any cycle not carrying read data; rData SHALL hold its last value when no read completes.
REQ-029 Back-to-back reads SHALL be supported at one per cycle at either latency; no bubbles.
REQ-030 Read and write in the same cycle to different addresses SHALL both complete.
REQ-031 Same address, RDW_MODE=0: rData SHALL be the pre-write word.
REQ-032 Same address, RDW_MODE=1: rData SHALL be the merged word (enabled bytes new, others old).
REQ-033 Reads in flight in the READY-to-CLEAR transition SHALL still complete with data sampled at the read edge.

Reset
REQ-034 resetn=0 SHALL immediately force rData=0, rValid=0, ready=0, clear counter=0, read pipeline empty, state CLEAR.
REQ-035 On resetn release the block SHALL run a full clear (REQ-019/020) before ready rises.
REQ-036 resetn asserted mid-clear or mid-read SHALL abort it; after release the clear restarts at address 0.
REQ-037 Array contents are not reset directly; the post-reset clear defines them as 0.

Verification (DATA_WIDTH=32, ADDRESS_WIDTH=4, DEPTH=12 unless stated)
REQ-038 Release resetn -> ready rises after exactly 12 posedges; reading addr 0..11 returns 0x00000000 each.
REQ-039 Write 0xDEADBEEF at addr 5, byteEn 4'b1111, then byteEn 4'b0101 data 0x11223344 -> read addr 5 returns 0xDE22BE44.
REQ-040 RDW same addr 3 holding 0xAAAAAAAA, write 0x55555555: RDW_MODE=0 -> 0xAAAAAAAA; RDW_MODE=1 -> 0x55555555.
REQ-041 READ_LATENCY=2, rEn on 4 consecutive cycles addr 0..3 -> 4 consecutive rValid pulses, starting 2 cycles after first request, data in order.
REQ-042 clr after writes, then clr again and resetn pulse at clear step 6 -> second clr ignored; after resetn release ready takes 12 cycles; all reads 0; wAddr 13 write and rAddr 14 read -> no array change, rData 0.

Source files
------------

// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - single-clock simple dual-port RAM with byte enables and a sequential clear engine.
// Reads in flight when a clear starts still complete; user traffic is ignored while clearing.
module ram_dp_clr #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096,
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wEn,
  input  logic [ADDRESS_WIDTH-1:0]  wAddr,
  input  logic [DATA_WIDTH-1:0]     wData,
  input  logic [DATA_WIDTH/8-1:0]   wByteEn,
  input  logic                      rEn,
  input  logic [ADDRESS_WIDTH-1:0]  rAddr,
  input  logic                      clr,
  output logic [DATA_WIDTH-1:0]     rData,
  output logic                      rValid,
  output logic                      ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] clr_cnt, clr_cnt_next;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     wr_user;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_data;
  logic [BYTES-1:0]         mem_be;

  logic                     rd_fire;
  logic                     rd_in_range;
  logic [DATA_WIDTH-1:0]    rd_word;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_next   = READY;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + ADDRESS_WIDTH'(1);
        end
      end
      READY: begin
        if (clr) state_next = CLEAR;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign ready   = (state == READY);
  assign wr_user = ready && wEn && ({1'b0, wAddr} < DEPTH_EXT);

  // The clear engine owns the write port for the whole clear sequence.
  always_comb begin
    mem_we   = wr_user;
    mem_addr = wAddr;
    mem_data = wData;
    mem_be   = wByteEn;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt;
      mem_data = '0;
      mem_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
  end

  assign rd_fire     = ready && rEn;
  assign rd_in_range = ({1'b0, rAddr} < DEPTH_EXT);

  // Write-first mode merges the enabled bytes of a same-address write into the read word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rAddr];
      if (RDW_MODE == 1 && wr_user && wAddr == rAddr) begin
        for (int i = 0; i < BYTES; i++) begin
          if (wByteEn[i]) rd_word[8*i +: 8] = wData[8*i +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        stage_valid <= 1'b0;
        stage_data  <= '0;
        rValid      <= 1'b0;
        rData       <= '0;
      end else begin
        stage_valid <= rd_fire;
        if (rd_fire) stage_data <= rd_word;
        rValid <= stage_valid;
        if (stage_valid) rData <= stage_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rValid <= 1'b0;
        rData  <= '0;
      end else begin
        rValid <= rd_fire;
        if (rd_fire) rData <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb/tb_ram_dp_clr.sv - directed bench for ram_dp_clr: read-old/latency-1, write-first, and latency-2 instances share stimulus.
module tb_ram_dp_clr;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  logic            clk     = 1'b0;
  logic            resetn  = 1'b1;
  logic            wEn     = 1'b0;
  logic [AW-1:0]   wAddr   = '0;
  logic [DW-1:0]   wData   = '0;
  logic [DW/8-1:0] wByteEn = '0;
  logic            rEn     = 1'b0;
  logic [AW-1:0]   rAddr   = '0;
  logic            clr     = 1'b0;

  logic [DW-1:0] rdata_a, rdata_b, rdata_c;
  logic          rvalid_a, rvalid_b, rvalid_c;
  logic          ready_a, ready_b, ready_c;

  int vectors     = 0;
  int miscompares = 0;

  ram_dp_clr #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .resetn(resetn), .wEn(wEn), .wAddr(wAddr), .wData(wData), .wByteEn(wByteEn),
    .rEn(rEn), .rAddr(rAddr), .clr(clr), .rData(rdata_a), .rValid(rvalid_a), .ready(ready_a));

  ram_dp_clr #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .RDW_MODE(1)) u_b (
    .clk(clk), .resetn(resetn), .wEn(wEn), .wAddr(wAddr), .wData(wData), .wByteEn(wByteEn),
    .rEn(rEn), .rAddr(rAddr), .clr(clr), .rData(rdata_b), .rValid(rvalid_b), .ready(ready_b));

  ram_dp_clr #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .RDW_MODE(0)) u_c (
    .clk(clk), .resetn(resetn), .wEn(wEn), .wAddr(wAddr), .wData(wData), .wByteEn(wByteEn),
    .rEn(rEn), .rAddr(rAddr), .clr(clr), .rData(rdata_c), .rValid(rvalid_c), .ready(ready_c));

  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    wEn = 1'b1; wAddr = a; wData = d; wByteEn = be;
    tick();
    wEn = 1'b0; wByteEn = '0;
  endtask

  task do_read(input logic [AW-1:0] a);
    rEn = 1'b1; rAddr = a;
    tick();
    rEn = 1'b0;
  endtask

  task test_reset();
    int edges;
    #1 resetn = 1'b0;
    #1;
    vectors++;
    if (rdata_a !== '0 || rvalid_a !== 1'b0 || ready_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rData=%h rValid=%b ready=%b, want 0/0/0", rdata_a, rvalid_a, ready_a);
    end
    repeat (3) tick();
    resetn = 1'b1;
    edges = 0;
    while (ready_a !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    vectors++;
    if (edges != DEPTH || ready_c !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_clear_len: ready after %0d edges (ready_c=%b), want %0d", edges, ready_c, DEPTH);
    end
  endtask

  task test_cleared_contents(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rEn = 1'b1; rAddr = AW'(i);
      tick();
      vectors++;
      if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
        miscompares++;
        $display("FAIL %s_addr%0d: rData=%h rValid=%b, want 00000000/1", tag, i, rdata_a, rvalid_a);
      end
    end
    rEn = 1'b0;
  endtask

  task test_byte_enable();
    do_write(4'd5, 32'hDEADBEEF, 4'b1111);
    do_write(4'd5, 32'h11223344, 4'b0101);
    do_read(4'd5);
    vectors++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL byte_enable: rData=%h rValid=%b, want DE22BE44/1", rdata_a, rvalid_a);
    end
    tick();
    vectors++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL idle_hold: rData=%h rValid=%b, want DE22BE44/0", rdata_a, rvalid_a);
    end
    do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
    do_read(4'd5);
    vectors++;
    if (rdata_a !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL zero_byte_en: rData=%h, want DE22BE44", rdata_a);
    end
  endtask

  task test_rdw();
    do_write(4'd3, 32'hAAAAAAAA, 4'b1111);
    wEn = 1'b1; wAddr = 4'd3; wData = 32'h55555555; wByteEn = 4'b1111;
    rEn = 1'b1; rAddr = 4'd3;
    tick();
    vectors++;
    if (rdata_a !== 32'hAAAAAAAA || rdata_b !== 32'h55555555) begin
      miscompares++;
      $display("FAIL rdw_same_addr: read_old=%h write_first=%h, want AAAAAAAA/55555555", rdata_a, rdata_b);
    end
    wAddr = 4'd7; wData = 32'h12345678; rAddr = 4'd5;
    tick();
    wEn = 1'b0; rEn = 1'b0;
    vectors++;
    if (rdata_a !== 32'hDE22BE44 || rdata_b !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL rdw_diff_addr_read: a=%h b=%h, want DE22BE44", rdata_a, rdata_b);
    end
    do_read(4'd7);
    vectors++;
    if (rdata_a !== 32'h12345678) begin
      miscompares++;
      $display("FAIL rdw_diff_addr_write: rData=%h, want 12345678", rdata_a);
    end
    do_read(4'd3);
    vectors++;
    if (rdata_a !== 32'h55555555 || rdata_b !== 32'h55555555) begin
      miscompares++;
      $display("FAIL rdw_after: a=%h b=%h, want 55555555", rdata_a, rdata_b);
    end
  endtask

  task test_back_to_back();
    for (int i = 0; i < 4; i++) do_write(AW'(i), 32'hA0000000 + DW'(i), 4'b1111);
    for (int i = 0; i < 6; i++) begin
      rEn = (i < 4); rAddr = AW'(i);
      tick();
      vectors++;
      if (rvalid_c !== (i >= 1 && i <= 4) ||
          ((i >= 1 && i <= 4) && rdata_c !== 32'hA0000000 + DW'(i - 1))) begin
        miscompares++;
        $display("FAIL lat2_cycle%0d: rData=%h rValid=%b, want valid=%0d data=%h",
                 i, rdata_c, rvalid_c, (i >= 1 && i <= 4), 32'hA0000000 + DW'(i - 1));
      end
      vectors++;
      if (rvalid_a !== (i < 4) || ((i < 4) && rdata_a !== 32'hA0000000 + DW'(i))) begin
        miscompares++;
        $display("FAIL lat1_cycle%0d: rData=%h rValid=%b, want valid=%0d data=%h",
                 i, rdata_a, rvalid_a, (i < 4), 32'hA0000000 + DW'(i));
      end
    end
    rEn = 1'b0;
  endtask

  task test_clear();
    int k;
    // Read launched on the same edge that starts the clear.
    clr = 1'b1; rEn = 1'b1; rAddr = 4'd5;
    tick();
    clr = 1'b0;
    wEn = 1'b1; wAddr = 4'd0; wData = 32'hFFFFFFFF; wByteEn = 4'b1111;
    vectors++;
    if (ready_a !== 1'b0 || rvalid_a !== 1'b1 || rdata_a !== 32'hDE22BE44 || rvalid_c !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_entry: ready=%b rValid=%b rData=%h rValid_c=%b, want 0/1/DE22BE44/0",
               ready_a, rvalid_a, rdata_a, rvalid_c);
    end
    k = 0;
    do begin
      tick();
      k++;
      clr = (k == 4);
      vectors++;
      if (rvalid_a !== 1'b0 || rdata_a !== 32'hDE22BE44 || rvalid_c !== (k == 1) ||
          (k == 1 && rdata_c !== 32'hDE22BE44)) begin
        miscompares++;
        $display("FAIL clr_step%0d: rValid=%b rData=%h rValid_c=%b rData_c=%h, want 0/DE22BE44/%0d/DE22BE44",
                 k, rvalid_a, rdata_a, rvalid_c, rdata_c, (k == 1));
      end
    end while (ready_a !== 1'b1 && k < 40);
    wEn = 1'b0; rEn = 1'b0; clr = 1'b0;
    vectors++;
    if (k != DEPTH) begin
      miscompares++;
      $display("FAIL clr_length: ready after %0d edges, want %0d", k, DEPTH);
    end
    do_read(4'd0);
    vectors++;
    if (rdata_a !== '0) begin
      miscompares++;
      $display("FAIL clr_write_blocked: rData=%h, want 00000000", rdata_a);
    end
    do_read(4'd5);
    vectors++;
    if (rdata_a !== '0) begin
      miscompares++;
      $display("FAIL clr_zeroed: rData=%h, want 00000000", rdata_a);
    end
  endtask

  task test_reset_mid_clear();
    int edges;
    do_write(4'd2, 32'h12345678, 4'b1111);
    do_read(4'd2);
    vectors++;
    if (rdata_a !== 32'h12345678) begin
      miscompares++;
      $display("FAIL pre_reset_read: rData=%h, want 12345678", rdata_a);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    vectors++;
    if (rdata_a !== '0 || rvalid_a !== 1'b0 || ready_a !== 1'b0 || rdata_c !== '0) begin
      miscompares++;
      $display("FAIL async_reset: rData=%h rValid=%b ready=%b rData_c=%h, want 0/0/0/0",
               rdata_a, rvalid_a, ready_a, rdata_c);
    end
    repeat (2) tick();
    resetn = 1'b1;
    edges = 0;
    while (ready_a !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    vectors++;
    if (edges != DEPTH) begin
      miscompares++;
      $display("FAIL reclear_length: ready after %0d edges, want %0d", edges, DEPTH);
    end
    test_cleared_contents("reclear");
  endtask

  task test_out_of_range();
    do_write(4'd4, 32'hCAFEF00D, 4'b1111);
    do_read(4'd4);
    vectors++;
    if (rdata_a !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL oor_setup: rData=%h, want CAFEF00D", rdata_a);
    end
    do_write(4'd13, 32'hFFFFFFFF, 4'b1111);
    do_read(4'd14);
    vectors++;
    if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
      miscompares++;
      $display("FAIL oor_read: rData=%h rValid=%b, want 00000000/1", rdata_a, rvalid_a);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      vectors++;
      if (rdata_a !== ((i == 4) ? 32'hCAFEF00D : 32'h0)) begin
        miscompares++;
        $display("FAIL oor_array_addr%0d: rData=%h, want %h", i, rdata_a, (i == 4) ? 32'hCAFEF00D : 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cleared_contents("post_reset");
    test_byte_enable();
    test_rdw();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
